// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types: data word and the RISC-MGMT memory arbiter state.
// Referenced by the arbiter, the hazard unit and the benches.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PIPE  = 2'd1,
        RMGMT = 2'd2,
        FAULT = 2'd3
    } rmgmt_arb_state_t;

    localparam logic [3:0] BYTE_EN_ALL = 4'hF;

endpackage

// File: rtl/rmgmt_mem_arbiter.sv
// Shares the data bus between the pipeline and the RISC-MGMT memory port.
// Define RMGMT_MEM_ALIGN_CHECK_EN to fault misaligned extension accesses.
module rmgmt_mem_arbiter
    import rv32i_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       req_mem,
    input  logic       mem_ren,
    input  logic       mem_wen,
    input  word_t      mem_addr,
    input  word_t      mem_store,
    output word_t      mem_load,
    output logic       mem_busy,
    output logic       mem_fault,
    input  logic       pipe_ren,
    input  logic       pipe_wen,
    input  word_t      pipe_addr,
    input  word_t      pipe_wdata,
    input  logic [3:0] pipe_byte_en,
    output word_t      pipe_rdata,
    output logic       pipe_busy,
    output logic       bus_ren,
    output logic       bus_wen,
    output word_t      bus_addr,
    output word_t      bus_wdata,
    output logic [3:0] bus_byte_en,
    input  word_t      bus_rdata,
    input  logic       bus_busy
);

    rmgmt_arb_state_t state;

    logic ext_valid;
    logic pipe_valid;
    logic ext_misaligned;

    assign ext_valid  = req_mem & (mem_ren | mem_wen);
    assign pipe_valid = pipe_ren | pipe_wen;

`ifdef RMGMT_MEM_ALIGN_CHECK_EN
    assign ext_misaligned = |mem_addr[1:0];
    assign mem_fault      = (state == FAULT);
`else
    assign ext_misaligned = 1'b0;
    assign mem_fault      = 1'b0;
`endif

    // Owner sees busy drop in the cycle the bus reports completion.
    assign mem_busy  = ext_valid
                     & ~((state == RMGMT) & ~bus_busy)
                     & (state != FAULT);
    assign pipe_busy = pipe_valid
                     & ~((state == PIPE) & ~bus_busy);

    assign pipe_rdata = bus_rdata;

    // Grant, hold and retire one bus transaction at a time; ext has priority.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            bus_ren     <= 1'b0;
            bus_wen     <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_byte_en <= '0;
            mem_load    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ext_valid && ext_misaligned) begin
                        state <= FAULT;
                    end else if (ext_valid) begin
                        bus_addr    <= mem_addr;
                        bus_wdata   <= mem_store;
                        bus_byte_en <= BYTE_EN_ALL;
                        bus_wen     <= mem_wen;
                        bus_ren     <= mem_ren & ~mem_wen;
                        state       <= RMGMT;
                    end else if (pipe_valid) begin
                        bus_addr    <= pipe_addr;
                        bus_wdata   <= pipe_wdata;
                        bus_byte_en <= pipe_byte_en;
                        bus_wen     <= pipe_wen;
                        bus_ren     <= pipe_ren & ~pipe_wen;
                        state       <= PIPE;
                    end
                end
                PIPE, RMGMT: begin
                    if (!bus_busy) begin
                        if (state == RMGMT && bus_ren) begin
                            mem_load <= bus_rdata;
                        end
                        bus_ren <= 1'b0;
                        bus_wen <= 1'b0;
                        state   <= IDLE;
                    end
                end
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmgmt_mem_arbiter.sv
// Directed bench for rmgmt_mem_arbiter.
// Covers reset, priority, write-wins, async reset and alignment handling.
module tb_rmgmt_mem_arbiter;
    import rv32i_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req_mem, mem_ren, mem_wen;
    word_t       mem_addr, mem_store, mem_load;
    logic        mem_busy, mem_fault;
    logic        pipe_ren, pipe_wen;
    word_t       pipe_addr, pipe_wdata, pipe_rdata;
    logic [3:0]  pipe_byte_en;
    logic        pipe_busy;
    logic        bus_ren, bus_wen;
    word_t       bus_addr, bus_wdata;
    logic [3:0]  bus_byte_en;
    word_t       bus_rdata;
    logic        bus_busy;

    int vectors = 0;
    int miscompares = 0;

    rmgmt_mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .req_mem(req_mem), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_store(mem_store),
        .mem_load(mem_load), .mem_busy(mem_busy), .mem_fault(mem_fault),
        .pipe_ren(pipe_ren), .pipe_wen(pipe_wen),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_byte_en(pipe_byte_en),
        .pipe_rdata(pipe_rdata), .pipe_busy(pipe_busy),
        .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_byte_en(bus_byte_en),
        .bus_rdata(bus_rdata), .bus_busy(bus_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        req_mem = 0; mem_ren = 0; mem_wen = 0;
        mem_addr = '0; mem_store = '0;
        pipe_ren = 0; pipe_wen = 0;
        pipe_addr = '0; pipe_wdata = '0; pipe_byte_en = '0;
        bus_rdata = '0; bus_busy = 1'b0;
        step(); step();

        chk("rst_bus_ren", 32'(bus_ren), 0);
        chk("rst_bus_wen", 32'(bus_wen), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_byte_en", 32'(bus_byte_en), 0);
        chk("rst_mem_load", mem_load, 0);
        chk("rst_mem_busy", 32'(mem_busy), 0);
        chk("rst_pipe_busy", 32'(pipe_busy), 0);
        chk("rst_mem_fault", 32'(mem_fault), 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        nRST = 1'b1;
        step();

        // Ext read, zero wait states
        req_mem = 1; mem_ren = 1; mem_addr = 32'h100;
        bus_rdata = 32'hDEADBEEF; bus_busy = 0;
        #1;
        chk("rd_c0_mem_busy", 32'(mem_busy), 1);
        step();
        chk("rd_c1_bus_ren", 32'(bus_ren), 1);
        chk("rd_c1_bus_wen", 32'(bus_wen), 0);
        chk("rd_c1_byte_en", 32'(bus_byte_en), 32'hF);
        chk("rd_c1_bus_addr", bus_addr, 32'h100);
        chk("rd_c1_mem_busy", 32'(mem_busy), 0);
        req_mem = 0; mem_ren = 0;
        step();
        chk("rd_c2_mem_load", mem_load, 32'hDEADBEEF);
        chk("rd_c2_bus_ren", 32'(bus_ren), 0);
        chk("rd_c2_state", 32'(dut.state), 32'(IDLE));

        // Ext write and pipe read together; ext first
        req_mem = 1; mem_wen = 1;
        mem_addr = 32'h200; mem_store = 32'h12345678;
        pipe_ren = 1; pipe_addr = 32'h300; pipe_byte_en = 4'h3;
        bus_busy = 1; bus_rdata = 32'hCAFEF00D;
        #1;
        chk("pr_c0_mem_busy", 32'(mem_busy), 1);
        chk("pr_c0_pipe_busy", 32'(pipe_busy), 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("pr_busy_bus_wen", 32'(bus_wen), 1);
            chk("pr_busy_bus_addr", bus_addr, 32'h200);
            chk("pr_busy_mem_busy", 32'(mem_busy), 1);
            chk("pr_busy_pipe_busy", 32'(pipe_busy), 1);
        end
        chk("pr_bus_wdata", bus_wdata, 32'h12345678);
        chk("pr_bus_ren", 32'(bus_ren), 0);
        step();
        bus_busy = 0;
        #1;
        chk("pr_c4_mem_busy", 32'(mem_busy), 0);
        chk("pr_c4_pipe_busy", 32'(pipe_busy), 1);
        req_mem = 0; mem_wen = 0;
        step();
        bus_busy = 1;
        #1;
        chk("pr_c5_state", 32'(dut.state), 32'(IDLE));
        chk("pr_c5_bus_wen", 32'(bus_wen), 0);
        chk("pr_c5_pipe_busy", 32'(pipe_busy), 1);
        step();
        chk("pr_c6_state", 32'(dut.state), 32'(PIPE));
        chk("pr_c6_bus_ren", 32'(bus_ren), 1);
        chk("pr_c6_bus_addr", bus_addr, 32'h300);
        chk("pr_c6_byte_en", 32'(bus_byte_en), 32'h3);
        chk("pr_c6_pipe_busy", 32'(pipe_busy), 1);
        bus_busy = 0;
        #1;
        chk("pr_c6_pipe_done", 32'(pipe_busy), 0);
        chk("pr_c6_pipe_rdata", pipe_rdata, 32'hCAFEF00D);
        chk("pr_mem_load_kept", mem_load, 32'hDEADBEEF);
        pipe_ren = 0;
        step();
        chk("pr_c7_bus_ren", 32'(bus_ren), 0);

        // Ext ren and wen both high -> write only
        req_mem = 1; mem_ren = 1; mem_wen = 1;
        mem_addr = 32'h40; mem_store = 32'hA5A55A5A;
        bus_busy = 0; bus_rdata = 32'h77777777;
        step();
        chk("rw_bus_wen", 32'(bus_wen), 1);
        chk("rw_bus_ren", 32'(bus_ren), 0);
        chk("rw_bus_wdata", bus_wdata, 32'hA5A55A5A);
        chk("rw_mem_busy", 32'(mem_busy), 0);
        req_mem = 0; mem_ren = 0; mem_wen = 0;
        step();
        chk("rw_mem_load_kept", mem_load, 32'hDEADBEEF);

        // Pipe ren and wen both high -> write only
        pipe_ren = 1; pipe_wen = 1;
        pipe_addr = 32'h44; pipe_wdata = 32'h11; pipe_byte_en = 4'hC;
        step();
        chk("prw_bus_wen", 32'(bus_wen), 1);
        chk("prw_bus_ren", 32'(bus_ren), 0);
        chk("prw_byte_en", 32'(bus_byte_en), 32'hC);
        chk("prw_bus_wdata", bus_wdata, 32'h11);
        pipe_ren = 0; pipe_wen = 0;
        step();

        // Async reset while an ext read is stalled
        req_mem = 1; mem_ren = 1; mem_addr = 32'h80; bus_busy = 1;
        step();
        chk("ar_pre_bus_ren", 32'(bus_ren), 1);
        chk("ar_pre_state", 32'(dut.state), 32'(RMGMT));
        nRST = 0;
        #1;
        chk("ar_bus_ren", 32'(bus_ren), 0);
        chk("ar_bus_addr", bus_addr, 0);
        chk("ar_byte_en", 32'(bus_byte_en), 0);
        chk("ar_state", 32'(dut.state), 32'(IDLE));
        chk("ar_mem_load", mem_load, 0);
        req_mem = 0; mem_ren = 0; bus_busy = 0;
        nRST = 1;
        step();

        // Misaligned ext read
        req_mem = 1; mem_ren = 1; mem_addr = 32'h102;
        bus_rdata = 32'h0BADF00D; bus_busy = 0;
        step();
`ifdef RMGMT_MEM_ALIGN_CHECK_EN
        chk("al_state", 32'(dut.state), 32'(FAULT));
        chk("al_bus_ren", 32'(bus_ren), 0);
        chk("al_mem_fault", 32'(mem_fault), 1);
        chk("al_mem_busy", 32'(mem_busy), 0);
        req_mem = 0; mem_ren = 0;
        step();
        chk("al_fault_drop", 32'(mem_fault), 0);
        chk("al_state_idle", 32'(dut.state), 32'(IDLE));
        chk("al_bus_ren_idle", 32'(bus_ren), 0);
        chk("al_mem_load", mem_load, 0);
`else
        chk("al_bus_addr", bus_addr, 32'h102);
        chk("al_bus_ren", 32'(bus_ren), 1);
        chk("al_mem_fault", 32'(mem_fault), 0);
        req_mem = 0; mem_ren = 0;
        step();
        chk("al_mem_load", mem_load, 32'h0BADF00D);
        chk("al_state_idle", 32'(dut.state), 32'(IDLE));
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
